fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000: first fetch address after reset.
REQ-002 SHALL have parameter INST_NOP, default 32'h0000_0013: o_inst value while empty or in reset.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port redirect_valid, input, 1: branch/jump redirect request from execute.
REQ-006 SHALL have port redirect_pc, input, 32: redirect target.
REQ-007 SHALL have port imem_req_valid, output, 1: instruction-memory read request valid.
REQ-008 SHALL have port imem_req_ready, input, 1: memory accepts request.
REQ-009 SHALL have port imem_req_addr, output, 32: request address (= current PC).
REQ-010 SHALL have port imem_rsp_valid, input, 1: read data valid.
REQ-011 SHALL have port imem_rsp_ready, output, 1: fetch accepts response.
REQ-012 SHALL have port imem_rsp_data, input, 32: instruction word.
REQ-013 SHALL have port o_valid, output, 1: instruction valid toward the fetch/decode pipeline register.
REQ-014 SHALL have port o_ready, input, 1: fetch/decode pipeline register accepts.
REQ-015 SHALL have ports o_pc, output, 32, and o_inst, output, 32: instruction address and word presented downstream.

Function
REQ-016 SHALL implement FSM states REQ (imem_req_valid=1), WAIT (imem_rsp_ready=1), HOLD (o_valid=1); at most one outstanding memory request.
REQ-017 REQ: on imem_req_valid&&imem_req_ready, SHALL go to WAIT; imem_req_addr SHALL stay stable while waiting for ready unless redirected.
REQ-018 WAIT: on imem_rsp_valid, SHALL capture pc/data into o_pc/o_inst and go to HOLD; o_valid SHALL rise the next cycle (request-to-o_valid latency with zero-wait memory = 2 cycles).
REQ-019 HOLD: o_pc/o_inst SHALL stay stable until o_valid&&o_ready; on that handshake, PC SHALL become o_pc+4 and FSM SHALL go to REQ.
REQ-020 PC increment SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 SHALL wrap to 32'h0000_0000.
REQ-021 redirect_valid in REQ SHALL load PC=redirect_pc; if the request handshakes the same cycle, that request SHALL be marked killed.
REQ-022 redirect_valid in WAIT SHALL load PC=redirect_pc and set a kill flag; the next response SHALL be consumed and discarded, then FSM SHALL go to REQ.
REQ-023 redirect_valid in HOLD SHALL drop the held instruction (o_valid=0 next cycle), load PC=redirect_pc, go to REQ; redirect SHALL take priority over a same-cycle o_ready handshake.
REQ-024 Response and redirect in the same WAIT cycle SHALL discard the response and go to REQ at redirect_pc.
REQ-025 imem_req_valid, imem_rsp_ready, o_valid SHALL be mutually exclusive and decoded from registered state only.

Reset
REQ-026 rst=1 SHALL set state=REQ, PC=RESET_PC, kill=0, o_valid=0, o_pc=RESET_PC, o_inst=INST_NOP; imem_req_valid SHALL be 0 during reset and 1 in the first cycle after.
REQ-027 rst mid-transaction SHALL abandon it; a response arriving after reset without a matching post-reset request SHALL be ignored (imem_rsp_ready=0 outside WAIT).

Configuration
REQ-028 With FETCH_PERF_EN defined: SHALL add outputs perf_fetch_cnt[31:0] (increments per o_valid&&o_ready) and perf_stall_cnt[31:0] (increments per cycle with o_valid&&!o_ready), both reset to 0, wrap at 2^32.
REQ-029 Without FETCH_PERF_EN: those ports and counters SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-030 Shared package core_pkg SHALL hold INST_ADDR_W=32, INST_DATA_W=32, CPU_RESET_ADDR, INST_NOP and enum fetch_state_e {REQ,WAIT,HOLD}.
REQ-031 Counters SHALL be in sub-module fetch_perf_cnt, instantiated only under FETCH_PERF_EN; FSM/PC logic SHALL stay in fetch_unit.

Verification
REQ-032 Reset release, zero-wait memory returning 32'h0000_0093 at 8000_0000, o_ready=1 -> o_pc=8000_0000, o_inst=0000_0093; next request addr 8000_0004.
REQ-033 o_ready=0 for 5 cycles in HOLD -> o_pc/o_inst stable, no new imem request; perf_stall_cnt=5 with FETCH_PERF_EN.
REQ-034 redirect_valid with redirect_pc=8000_0100 in WAIT, response 3 cycles later -> response discarded, o_valid stays 0, next imem_req_addr=8000_0100.
REQ-035 redirect to 8000_0200 in HOLD while o_ready=1 -> no downstream handshake, next request addr 8000_0200.
REQ-036 redirect_pc=FFFF_FFFC, one handshake -> next imem_req_addr=0000_0000.
REQ-037 rst asserted in WAIT, stale imem_rsp_valid after release -> imem_rsp_ready=0, first request at RESET_PC, o_inst=INST_NOP until valid.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared core definitions: instruction bus widths, reset
//                address, the canonical NOP encoding and the fetch FSM state
//                type, plus a small sequential-PC helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_DATA_W = 32;
    localparam int PERF_CNT_W  = 32;

    localparam logic [INST_ADDR_W-1:0] CPU_RESET_ADDR = 32'h8000_0000;
    localparam logic [INST_DATA_W-1:0] INST_NOP       = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    // Sequential successor of a word-aligned PC; wraps modulo 2^32.
    function automatic logic [INST_ADDR_W-1:0] next_seq_pc(input logic [INST_ADDR_W-1:0] pc);
        return pc + INST_ADDR_W'(4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Instruction-memory request/response bus between the fetch
//                unit (master) and the instruction memory (slave).
//                Request channel : imem_req_valid / imem_req_ready / imem_req_addr
//                Response channel: imem_rsp_valid / imem_rsp_ready / imem_rsp_data
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    import core_pkg::*;

    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [INST_ADDR_W-1:0] imem_req_addr;
    logic                   imem_rsp_valid;
    logic                   imem_rsp_ready;
    logic [INST_DATA_W-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        output imem_rsp_ready,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        input  imem_rsp_ready,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface
`default_nettype wire

// File: rtl/fetch_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_perf_cnt
//  Description : Fetch performance counters observing the downstream
//                valid/ready pair.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                valid, ready  - downstream handshake being observed
//                fetch_cnt     - cycles with valid && ready (wraps at 2^32)
//                stall_cnt     - cycles with valid && !ready (wraps at 2^32)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_perf_cnt
    import core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  ready,
    output logic [PERF_CNT_W-1:0] fetch_cnt,
    output logic [PERF_CNT_W-1:0] stall_cnt
);

    logic [PERF_CNT_W-1:0] r_fetch_cnt;
    logic [PERF_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (valid && ready) begin
                r_fetch_cnt <= r_fetch_cnt + PERF_CNT_W'(1);
            end
            if (valid && !ready) begin
                r_stall_cnt <= r_stall_cnt + PERF_CNT_W'(1);
            end
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Single-outstanding instruction fetch stage. A three-state
//                FSM (REQ -> WAIT -> HOLD) issues one memory read at the
//                current PC, captures the returned word and holds it for
//                the decode stage. Redirects from execute replace the PC at
//                any point and squash whatever is in flight.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                redirect_valid  - branch/jump redirect request
//                redirect_pc     - redirect target
//                imem            - instruction-memory bus (master modport)
//                o_valid/o_ready - handshake toward fetch/decode register
//                o_pc, o_inst    - instruction address and word
//                perf_fetch_cnt, perf_stall_cnt (FETCH_PERF_EN only)
//  Config      : define FETCH_PERF_EN to add the performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [core_pkg::INST_ADDR_W-1:0] RESET_PC = core_pkg::CPU_RESET_ADDR,
    parameter logic [core_pkg::INST_DATA_W-1:0] INST_NOP = core_pkg::INST_NOP
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             redirect_valid,
    input  logic [core_pkg::INST_ADDR_W-1:0] redirect_pc,
    fetch_unit_if.master                     imem,
    output logic                             o_valid,
    input  logic                             o_ready,
    output logic [core_pkg::INST_ADDR_W-1:0] o_pc,
    output logic [core_pkg::INST_DATA_W-1:0] o_inst
`ifdef FETCH_PERF_EN
    ,
    output logic [core_pkg::PERF_CNT_W-1:0]  perf_fetch_cnt,
    output logic [core_pkg::PERF_CNT_W-1:0]  perf_stall_cnt
`endif
);

    import core_pkg::*;

    fetch_state_e           r_state;
    logic [INST_ADDR_W-1:0] r_pc;
    logic                   r_kill;     // outstanding request belongs to a squashed path
    logic [INST_ADDR_W-1:0] r_o_pc;
    logic [INST_DATA_W-1:0] r_o_inst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= REQ;
            r_pc     <= RESET_PC;
            r_kill   <= 1'b0;
            r_o_pc   <= RESET_PC;
            r_o_inst <= INST_NOP;
        end else begin
            case (r_state)
                REQ: begin
                    // The address on the bus is r_pc, so a redirect here only
                    // changes what the next request will carry.
                    if (redirect_valid) begin
                        r_pc <= redirect_pc;
                    end
                    if (imem.imem_req_ready) begin
                        r_state <= WAIT;
                        r_kill  <= redirect_valid;
                    end
                end

                WAIT: begin
                    if (redirect_valid) begin
                        r_pc <= redirect_pc;
                    end
                    if (imem.imem_rsp_valid) begin
                        r_kill <= 1'b0;
                        if (redirect_valid || r_kill) begin
                            // Wrong-path data: consume it and refetch.
                            r_state <= REQ;
                        end else begin
                            r_state  <= HOLD;
                            r_o_pc   <= r_pc;
                            r_o_inst <= imem.imem_rsp_data;
                        end
                    end else if (redirect_valid) begin
                        r_kill <= 1'b1;
                    end
                end

                HOLD: begin
                    // Redirect beats a same-cycle downstream accept.
                    if (redirect_valid) begin
                        r_pc     <= redirect_pc;
                        r_state  <= REQ;
                        r_o_inst <= INST_NOP;
                    end else if (o_ready) begin
                        r_pc     <= next_seq_pc(r_o_pc);
                        r_state  <= REQ;
                        r_o_inst <= INST_NOP;
                    end
                end

                default: begin
                    r_state <= REQ;
                end
            endcase
        end
    end

    // Handshake outputs come from the state register; they are additionally
    // held low while rst is asserted so nothing is offered during reset.
    assign imem.imem_req_valid = (r_state == REQ)  && !rst;
    assign imem.imem_rsp_ready = (r_state == WAIT) && !rst;
    assign o_valid             = (r_state == HOLD) && !rst;
    assign imem.imem_req_addr  = r_pc;
    assign o_pc                = r_o_pc;
    assign o_inst              = r_o_inst;

`ifdef FETCH_PERF_EN
    fetch_perf_cnt u_perf (
        .clk       (clk),
        .rst       (rst),
        .valid     (o_valid),
        .ready     (o_ready),
        .fetch_cnt (perf_fetch_cnt),
        .stall_cnt (perf_stall_cnt)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A transaction-level
//                reference model (expected next PC, outstanding/killed
//                request, held instruction) predicts every output each
//                cycle; directed scenarios are followed by random traffic.
//                Memory word at address a is a ^ 32'h8000_0093.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] C_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] C_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (C_RESET_PC),
        .INST_NOP (C_NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (bus),
        .o_valid        (o_valid),
        .o_ready        (o_ready),
        .o_pc           (o_pc),
        .o_inst         (o_inst)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h8000_0093;
    endfunction

    // Reference model state
    logic [31:0] exp_pc;
    bit          outstanding, out_killed, holding, last_rst;
    int          m_fetch, m_stall, deliveries, idle;
    // Memory model state
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          mem_rdy_pct, lat_min, lat_max;

    // One clock cycle: drive at negedge, check outputs, advance models.
    task automatic cycle(input logic rst_i, input logic redir_i,
                         input logic [31:0] rpc_i, input logic rdy_i);
        bit req_hs, rsp_hs, deliver;
        @(negedge clk);
        rst            = rst_i;
        redirect_valid = redir_i;
        redirect_pc    = rpc_i;
        o_ready        = rdy_i;
        bus.imem_req_ready = ($urandom_range(99) < mem_rdy_pct);
        bus.imem_rsp_valid = mem_busy && (mem_cnt == 0);
        bus.imem_rsp_data  = bus.imem_rsp_valid ? mem_word(mem_addr) : $urandom();
        #1;
        if (rst_i) begin
            check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
            check("rst_rsp_ready", 32'(bus.imem_rsp_ready), 32'd0);
            check("rst_o_valid",   32'(o_valid), 32'd0);
        end else begin
            check("req_valid", 32'(bus.imem_req_valid), 32'(!outstanding && !holding));
            check("rsp_ready", 32'(bus.imem_rsp_ready), 32'(outstanding));
            check("o_valid",   32'(o_valid), 32'(holding));
        end
        if (last_rst) begin
            check("rst_o_pc",   o_pc,   C_RESET_PC);
            check("rst_o_inst", o_inst, C_NOP);
        end else if (o_valid) begin
            check("o_pc",   o_pc,   exp_pc);
            check("o_inst", o_inst, mem_word(exp_pc));
        end else if (!rst_i) begin
            check("o_inst_empty", o_inst, C_NOP);
        end
        if (!rst_i && bus.imem_req_valid)
            check("req_addr", bus.imem_req_addr, exp_pc);
`ifdef FETCH_PERF_EN
        check("perf_fetch", perf_fetch_cnt, 32'(m_fetch));
        check("perf_stall", perf_stall_cnt, 32'(m_stall));
`endif
        req_hs = !rst_i && bus.imem_req_valid && bus.imem_req_ready;
        rsp_hs = !rst_i && bus.imem_rsp_valid && bus.imem_rsp_ready;
        // memory ignores fetch reset: a stale response stays on offer
        if (rsp_hs) mem_busy = 1'b0;
        else if (mem_busy && mem_cnt > 0) mem_cnt--;
        if (req_hs) begin
            mem_busy = 1'b1;
            mem_addr = bus.imem_req_addr;
            mem_cnt  = int'($urandom_range(lat_max, lat_min));
        end
        last_rst = rst_i;
        if (rst_i) begin
            exp_pc = C_RESET_PC; outstanding = 0; out_killed = 0; holding = 0;
            m_fetch = 0; m_stall = 0; idle = 0;
        end else begin
            if (holding && rdy_i)  m_fetch++;
            if (holding && !rdy_i) m_stall++;
            deliver = holding && rdy_i && !redir_i;
            if (redir_i) begin
                exp_pc  = rpc_i;
                holding = 0;
            end else if (deliver) begin
                exp_pc  = exp_pc + 32'd4;
                holding = 0;
                deliveries++;
            end
            if (req_hs) begin
                outstanding = 1;
                out_killed  = redir_i;
            end else if (rsp_hs) begin
                outstanding = 0;
                holding     = !out_killed && !redir_i;
            end else if (redir_i && outstanding) begin
                out_killed = 1;
            end
            idle = deliver ? 0 : idle + 1;
            if (idle == 400) check("watchdog_idle", 32'(idle), 32'd0);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic wait_valid(input logic rdy_i);
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cycle(1'b0, 1'b0, 32'd0, rdy_i);
            seen = o_valid;
        end
        if (!seen) check("timeout_valid", 32'(o_valid), 32'd1);
    endtask

    task automatic wait_rsp_ready(input logic rdy_i);
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cycle(1'b0, 1'b0, 32'd0, rdy_i);
            seen = bus.imem_rsp_ready;
        end
        if (!seen) check("timeout_wait", 32'(bus.imem_rsp_ready), 32'd1);
    endtask

    task automatic wait_req(input logic rdy_i);
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cycle(1'b0, 1'b0, 32'd0, rdy_i);
            seen = bus.imem_req_valid;
        end
        if (!seen) check("timeout_req", 32'(bus.imem_req_valid), 32'd1);
    endtask

    initial begin
        logic [31:0] hp, hi;
        bit          done;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; o_ready = 1'b0;
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
        exp_pc = C_RESET_PC; outstanding = 0; out_killed = 0; holding = 0; last_rst = 0;
        m_fetch = 0; m_stall = 0; deliveries = 0; idle = 0;
        mem_busy = 0; mem_addr = '0; mem_cnt = 0;
        mem_rdy_pct = 100; lat_min = 0; lat_max = 0;

        // Reset release, zero-wait memory, downstream always ready
        do_reset(3);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("t1_first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("t1_first_req_addr", bus.imem_req_addr, 32'h8000_0000);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("t1_in_wait", 32'(bus.imem_rsp_ready), 32'd1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("t1_o_valid", 32'(o_valid), 32'd1);
        check("t1_o_pc", o_pc, 32'h8000_0000);
        check("t1_o_inst", o_inst, 32'h0000_0093);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("t1_next_addr", bus.imem_req_addr, 32'h8000_0004);

        // Downstream stall for 5 cycles in HOLD
        do_reset(2);
        wait_valid(1'b0);
        hp = o_pc; hi = o_inst;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b0);
            check("t2_pc_stable", o_pc, hp);
            check("t2_inst_stable", o_inst, hi);
            check("t2_no_req", 32'(bus.imem_req_valid), 32'd0);
        end
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("t2_still_valid", 32'(o_valid), 32'd1);
`ifdef FETCH_PERF_EN
        check("t2_stall_cnt", perf_stall_cnt, 32'd5);
`endif

        // Redirect while waiting on a 3-cycle-latency response
        lat_min = 3; lat_max = 3;
        wait_rsp_ready(1'b1);
        cycle(1'b0, 1'b1, 32'h8000_0100, 1'b1);
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b1);
            check("t3_no_valid", 32'(o_valid), 32'd0);
            done = bus.imem_req_valid;
        end
        check("t3_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("t3_req_addr", bus.imem_req_addr, 32'h8000_0100);

        // Redirect in HOLD wins over a same-cycle accept
        lat_min = 0; lat_max = 0;
        wait_valid(1'b0);
        cycle(1'b0, 1'b1, 32'h8000_0200, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check("t4_dropped", 32'(o_valid), 32'd0);
        check("t4_req_addr", bus.imem_req_addr, 32'h8000_0200);

        // PC wrap at the top of the address space
        wait_valid(1'b0);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        wait_valid(1'b1);
        check("t5_o_pc", o_pc, 32'hFFFF_FFFC);
        wait_req(1'b1);
        check("t5_wrap_addr", bus.imem_req_addr, 32'h0000_0000);

        // Reset during WAIT, stale response offered afterwards
        lat_min = 2; lat_max = 2;
        do_reset(2);
        wait_rsp_ready(1'b1);
        do_reset(3);
        mem_rdy_pct = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b1);
            check("t6_rsp_ready", 32'(bus.imem_rsp_ready), 32'd0);
            check("t6_nop", o_inst, C_NOP);
            check("t6_addr", bus.imem_req_addr, C_RESET_PC);
        end
        mem_rdy_pct = 100; lat_min = 0; lat_max = 0;
        wait_valid(1'b1);
        check("t6_o_pc", o_pc, C_RESET_PC);
        check("t6_o_inst", o_inst, 32'h0000_0093);

        // Random traffic
        do_reset(2);
        deliveries = 0;
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] rpc;
            if (i % 500 == 0) begin
                mem_rdy_pct = int'($urandom_range(100, 30));
                lat_max     = int'($urandom_range(3, 0));
                lat_min     = 0;
            end
            rpc = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC : {$urandom() & 32'hFFFF_FFFC};
            cycle(($urandom_range(999) < 4), ($urandom_range(99) < 4), rpc,
                  ($urandom_range(99) < 65));
        end
        check("progress", 32'(deliveries > 200), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
